data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Two-port arbiter that shares the single-ported data memory between two word-access requesters: port 0 (CPU load/store unit) and port 1 (debug/DMA loader). It accepts one request at a time with round-robin fairness and latches the winner's command. It then drives the memory's write-enable, address and write-data for exactly one cycle, and returns registered read data with an ack. Accesses that are misaligned or out of range are rejected with an error and never reach memory.

Parameters:
MEMORY_DEPTH, 256, number of 32-bit words in the attached memory; the legal byte-address range is 0 .. MEMORY_DEPTH*4-1.

Ports:
clk  in  1  single system clock; all state updates on its rising edge.
rst_n  in  1  reset; asynchronous assertion, active-low.
p0_req / p1_req  in  1  request; held high with the command stable until the matching ack.
p0_we / p1_we  in  1  1 = write, 0 = read.
p0_addr / p1_addr  in  32  byte address; word index is addr[31:2].
p0_wdata / p1_wdata  in  32  write data.
p0_ack / p1_ack  out  1  one-cycle completion pulse.
p0_err / p1_err  out  1  valid only with ack; 1 = access rejected.
p0_rdata / p1_rdata  out  32  read data; valid with ack, held until the next ack on that port.
mem_we  out  1  memory write enable.
mem_a  out  32  memory byte address.
mem_wd  out  32  memory write data.
mem_rd  in  32  memory read data; combinational from mem_a.
busy  out  1  1 while in ACCESS or DONE.
gnt_id  out  1  port currently or last granted.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- States: IDLE, ACCESS, DONE.
- Reset values, forced immediately on rst_n low (including mid-operation):
  - state = IDLE; all acks, errs and mem_we = 0.
  - mem_a, mem_wd, p0_rdata, p1_rdata = 0.
  - last = 1 (so port 0 wins the first tie); gnt_id = 0.
- IDLE, on a clock edge with any request high:
  - Only one requester high: that port wins.
  - Both high: the port != last wins.
  - Latch the winner's we, addr and wdata; set gnt_id and last to the winner; go to ACCESS.
  - No requests: stay in IDLE.
- Error check, evaluated on the latched address: err = (addr[1:0] != 0) or (addr[31:2] >= MEMORY_DEPTH).
- ACCESS (exactly one cycle):
  - mem_a = latched address.
  - mem_wd = latched wdata.
  - mem_we = latched we AND NOT err.
  - On the closing edge:
    - Winner's ack = 1 and err = computed err.
    - Winner's rdata = mem_rd for a read with no error; 0 when err = 1; unchanged for a successful write.
    - mem_we goes to 0; go to DONE.
- DONE (one cycle):
  - ack and err are visible this cycle.
  - All requests are ignored; the requester must drop req here.
  - On the next edge: ack and err go to 0; go to IDLE.
- Latency and throughput:
  - Request sampled at edge E0 -> memory driven in cycle E0..E1 -> ack high in cycle E1..E2.
  - Maximum one access per 3 cycles.
- mem_we is high only during ACCESS; it never asserts for a rejected access.
- The losing requester keeps waiting; it is granted at the next IDLE decision.
- Fairness: under continuous contention grants strictly alternate 0,1,0,1…
- A req that drops while not granted is simply forgotten; nothing is latched.
- Changing a command while req is high and not yet granted is permitted. The value latched is the one present at the granting edge.
- mem_a and mem_wd hold their last values outside ACCESS; mem_we must be 0 there.

Test Plan:
- Reset, then p0 write addr 0x04 data 0xDEADBEEF -> mem_we=1 for exactly 1 cycle, mem_a=0x04, p0_ack pulse 2 cycles after the request edge, p0_err=0.
- p1 read addr 0x04 -> p1_ack with p1_rdata=0xDEADBEEF, p1_err=0, mem_we stays 0.
- p0 and p1 both request continuously for 4 accesses each, starting from reset -> grant order 0,1,0,1,0,1,0,1; each ack lands on the correct port only.
- p0 write addr 0x06 (misaligned), then addr 0x400 with MEMORY_DEPTH=256 -> p0_err=1 with ack, mem_we never asserted, p0_rdata=0; a read of 0x04 still returns 0xDEADBEEF.
- rst_n pulsed low during ACCESS of a p1 write to 0x10 -> mem_we and acks drop immediately; after release state is IDLE, no ack is issued, and p0 wins a simultaneous request.
- p1 writes 0xCAFEBABE to 0x3FC (last word), then reads it back -> rdata=0xCAFEBABE, err=0.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester, memory and status signals of the data memory arbiter
interface data_mem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_ack;
  logic        p0_err;
  logic [31:0] p0_rdata;
  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_ack;
  logic        p1_err;
  logic [31:0] p1_rdata;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        busy;
  logic        gnt_id;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rd,
    output p0_ack, p0_err, p0_rdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_we, mem_a, mem_wd, busy, gnt_id
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rd,
    input  p0_ack, p0_err, p0_rdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_we, mem_a, mem_wd, busy, gnt_id
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin two-port arbiter for a single-ported word memory
module data_mem_arbiter #(
  parameter int MEMORY_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_arbiter_if.slave bus
);

  localparam logic [31:0] DEPTH_W = 32'(MEMORY_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        win;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;

  // On a tie the port that did not win last time takes the grant
  assign win       = (bus.p0_req && bus.p1_req) ? ~last_q : bus.p1_req;
  assign sel_we    = win ? bus.p1_we    : bus.p0_we;
  assign sel_addr  = win ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = win ? bus.p1_wdata : bus.p0_wdata;
  assign sel_err   = (sel_addr[1:0] != 2'b00) || ({2'b00, sel_addr[31:2]} >= DEPTH_W);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    err_d     = err_q;
    mem_we_d  = 1'b0;
    mem_a_d   = mem_a_q;
    mem_wd_d  = mem_wd_q;
    ack_d     = 2'b00;
    rsp_err_d = 2'b00;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          gnt_d    = win;
          last_d   = win;
          we_d     = sel_we;
          err_d    = sel_err;
          mem_a_d  = sel_addr;
          mem_wd_d = sel_wdata;
          mem_we_d = sel_we && !sel_err;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        ack_d[gnt_q]     = 1'b1;
        rsp_err_d[gnt_q] = err_q;
        // Writes leave the port's read data untouched
        if (err_q || !we_q) begin
          if (gnt_q) rdata1_d = err_q ? 32'h0 : bus.mem_rd;
          else       rdata0_d = err_q ? 32'h0 : bus.mem_rd;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_a_q   <= 32'h0;
      mem_wd_q  <= 32'h0;
      ack_q     <= 2'b00;
      rsp_err_q <= 2'b00;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      err_q     <= err_d;
      mem_we_q  <= mem_we_d;
      mem_a_q   <= mem_a_d;
      mem_wd_q  <= mem_wd_d;
      ack_q     <= ack_d;
      rsp_err_q <= rsp_err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign bus.p0_ack   = ack_q[0];
  assign bus.p1_ack   = ack_q[1];
  assign bus.p0_err   = rsp_err_q[0];
  assign bus.p1_err   = rsp_err_q[1];
  assign bus.p0_rdata = rdata0_q;
  assign bus.p1_rdata = rdata1_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_wd   = mem_wd_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.gnt_id   = gnt_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter_if bus();

  data_mem_arbiter #(.MEMORY_DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Attached memory
  logic [31:0] tb_mem [0:255];
  assign bus.mem_rd = (bus.mem_a[31:10] == 22'h0) ? tb_mem[bus.mem_a[9:2]] : 32'h0BAD0BAD;
  always @(posedge clk) if (bus.mem_we) tb_mem[bus.mem_a[9:2]] <= bus.mem_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: phase 0 free, 1 memory driven, 2 response visible
  logic [31:0] ref_mem [0:255];
  int          phase = 0;
  logic        m_last = 1'b1, m_port = 1'b0, m_we = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
  logic        e_ack0 = 1'b0, e_ack1 = 1'b0, e_err0 = 1'b0, e_err1 = 1'b0, e_gnt = 1'b0;
  logic [31:0] e_rd0 = 32'h0, e_rd1 = 32'h0, e_mem_a = 32'h0, e_mem_wd = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; m_last = 1'b1; e_gnt = 1'b0;
      e_ack0 = 1'b0; e_ack1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
      e_rd0 = 32'h0; e_rd1 = 32'h0; e_mem_a = 32'h0; e_mem_wd = 32'h0;
    end else if (phase == 0) begin
      e_ack0 = 1'b0; e_ack1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
      if (bus.p0_req || bus.p1_req) begin
        if (bus.p0_req && bus.p1_req) m_port = (m_last == 1'b0);
        else                          m_port = bus.p1_req;
        m_we    = m_port ? bus.p1_we    : bus.p0_we;
        m_addr  = m_port ? bus.p1_addr  : bus.p0_addr;
        m_wdata = m_port ? bus.p1_wdata : bus.p0_wdata;
        m_err   = (m_addr % 4 != 0) || (m_addr / 4 >= 256);
        m_last  = m_port; e_gnt = m_port;
        e_mem_a = m_addr; e_mem_wd = m_wdata;
        phase   = 1;
      end
    end else if (phase == 1) begin
      if (m_port) begin e_ack1 = 1'b1; e_err1 = m_err; end
      else        begin e_ack0 = 1'b1; e_err0 = m_err; end
      if (m_err) begin
        if (m_port) e_rd1 = 32'h0; else e_rd0 = 32'h0;
      end else if (m_we) begin
        ref_mem[m_addr / 4] = m_wdata;
      end else begin
        if (m_port) e_rd1 = ref_mem[m_addr / 4]; else e_rd0 = ref_mem[m_addr / 4];
      end
      phase = 2;
    end else begin
      e_ack0 = 1'b0; e_ack1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
      phase = 0;
    end
  end

  int we_cnt = 0;
  int gq[$];

  always @(negedge clk) begin
    chk("mem_we", bus.mem_we, (phase == 1 && m_we && !m_err));
    chk("mem_a", bus.mem_a, e_mem_a);
    chk("mem_wd", bus.mem_wd, e_mem_wd);
    chk("p0_ack", bus.p0_ack, e_ack0);
    chk("p1_ack", bus.p1_ack, e_ack1);
    chk("p0_err", bus.p0_err, e_err0);
    chk("p1_err", bus.p1_err, e_err1);
    chk("p0_rdata", bus.p0_rdata, e_rd0);
    chk("p1_rdata", bus.p1_rdata, e_rd1);
    chk("busy", bus.busy, (phase != 0));
    chk("gnt_id", bus.gnt_id, e_gnt);
    if (bus.mem_we) we_cnt++;
    if (bus.p0_ack) gq.push_back(0);
    if (bus.p1_ack) gq.push_back(1);
  end

  task automatic do_access(input int port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output bit e,
                           output logic [31:0] rd, output int lat);
    bit got;
    #1;
    if (port == 0) begin
      bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_req = 1'b1;
    end else begin
      bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_req = 1'b1;
    end
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      got = (port == 0) ? bus.p0_ack : bus.p1_ack;
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    e  = (port == 0) ? bus.p0_err : bus.p1_err;
    rd = (port == 0) ? bus.p0_rdata : bus.p1_rdata;
    #1;
    if (port == 0) bus.p0_req = 1'b0; else bus.p1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic port_loop(input int port, input int n);
    bit e;
    logic [31:0] rd;
    int lat;
    for (int i = 0; i < n; i++) begin
      if (port == 0) do_access(0, 1'b1, 32'h40 + 32'(4 * i), 32'h1000_0000 + 32'(i), e, rd, lat);
      else           do_access(1, 1'b0, 32'h40 + 32'(4 * i), 32'h0, e, rd, lat);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  bit          e;
  logic [31:0] rd;
  int          lat, w0;

  initial begin
    for (int i = 0; i < 256; i++) begin tb_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 32'h0; bus.p0_wdata = 32'h0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 32'h0; bus.p1_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_gnt", bus.gnt_id, 1'b0);
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_p0_rdata", bus.p0_rdata, 32'h0);
    #1 rst_n = 1'b1;

    // Write then read back across ports
    w0 = we_cnt;
    do_access(0, 1'b1, 32'h04, 32'hDEADBEEF, e, rd, lat);
    chk("wr_latency", lat, 2);
    chk("wr_err", e, 1'b0);
    chk("wr_we_cycles", we_cnt - w0, 1);
    chk("wr_mem", tb_mem[1], 32'hDEADBEEF);
    w0 = we_cnt;
    do_access(1, 1'b0, 32'h04, 32'h0, e, rd, lat);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", e, 1'b0);
    chk("rd_no_we", we_cnt - w0, 0);

    // Rejected accesses
    do_access(0, 1'b0, 32'h04, 32'h0, e, rd, lat);
    chk("p0_rd_pre", rd, 32'hDEADBEEF);
    w0 = we_cnt;
    do_access(0, 1'b1, 32'h06, 32'h11111111, e, rd, lat);
    chk("mis_err", e, 1'b1);
    chk("mis_rdata", rd, 32'h0);
    do_access(0, 1'b1, 32'h400, 32'h22222222, e, rd, lat);
    chk("oor_err", e, 1'b1);
    chk("oor_rdata", rd, 32'h0);
    chk("err_no_we", we_cnt - w0, 0);
    do_access(0, 1'b0, 32'h04, 32'h0, e, rd, lat);
    chk("rd_after_err", rd, 32'hDEADBEEF);

    // Continuous contention from reset
    pulse_reset();
    gq.delete();
    fork
      port_loop(0, 4);
      port_loop(1, 4);
    join
    chk("grant_count", gq.size(), 8);
    for (int i = 0; i < 8 && i < gq.size(); i++) chk("grant_order", gq[i], i % 2);
    chk("contend_rdata", bus.p1_rdata, 32'h1000_0003);

    // Reset during ACCESS of a p1 write
    @(negedge clk);
    #1 bus.p1_we = 1'b1; bus.p1_addr = 32'h10; bus.p1_wdata = 32'h55AA55AA; bus.p1_req = 1'b1;
    @(negedge clk);
    chk("acc_mem_we", bus.mem_we, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", bus.mem_we, 1'b0);
    chk("rst_mid_ack", {bus.p0_ack, bus.p1_ack}, 2'b00);
    chk("rst_mid_busy", bus.busy, 1'b0);
    bus.p1_req = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_write", tb_mem[4], 32'h0);
    gq.delete();
    fork
      do_access(0, 1'b0, 32'h04, 32'h0, e, rd, lat);
      begin
        bit e1; logic [31:0] rd1; int lat1;
        do_access(1, 1'b0, 32'h04, 32'h0, e1, rd1, lat1);
      end
    join
    chk("post_rst_count", gq.size(), 2);
    if (gq.size() > 0) chk("post_rst_first", gq[0], 0);

    // Last legal word
    do_access(1, 1'b1, 32'h3FC, 32'hCAFEBABE, e, rd, lat);
    chk("last_wr_err", e, 1'b0);
    do_access(1, 1'b0, 32'h3FC, 32'h0, e, rd, lat);
    chk("last_rd_data", rd, 32'hCAFEBABE);
    chk("last_rd_err", e, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
